// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the pipeline front-end sequencer: FSM state encoding,
// next-PC select codes and default widths.
package fetch_sequencer_pkg;

    localparam int REG_W_DEF       = 5;
    localparam int CNT_W_DEF       = 16;
    localparam int HOLD_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        ST_HOLD      = 2'b00,
        ST_RUN       = 2'b01,
        ST_IMEM_WAIT = 2'b10
    } state_e;

    typedef logic [1:0] pc_sel_t;

    localparam pc_sel_t PC_SEL_PC4    = 2'b00;
    localparam pc_sel_t PC_SEL_BRANCH = 2'b01;
    localparam pc_sel_t PC_SEL_JUMP   = 2'b10;

endpackage : fetch_sequencer_pkg

// File: rtl/fetch_sequencer_if.sv
// Bundle between the pipeline datapath (master) and the front-end sequencer (slave):
// hazard inputs in, PC/pipeline-register control and performance counters out.
interface fetch_sequencer_if
    import fetch_sequencer_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rt;
    logic             ex_branch_taken;
    logic             id_jump;
    logic             imem_ready;

    logic             pc_write;
    pc_sel_t          pc_sel;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, ex_mem_read, ex_rt, ex_branch_taken, id_jump, imem_ready,
        input  pc_write, pc_sel, ifid_write, ifid_flush, idex_flush, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, ex_mem_read, ex_rt, ex_branch_taken, id_jump, imem_ready,
        output pc_write, pc_sel, ifid_write, ifid_flush, idex_flush, stall_cnt, flush_cnt
    );

endinterface : fetch_sequencer_if

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter used for the stall and redirect performance counters;
// sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : sat_counter

// File: rtl/fetch_sequencer.sv
// Front-end hazard sequencer for the 5-stage pipeline: post-reset hold, branch/jump
// redirects, load-use bubbles and instruction-memory wait states.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int REG_W       = REG_W_DEF
) (
    input logic               clk,
    input logic               reset,
    fetch_sequencer_if.slave  bus
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [REG_W-1:0]  ex_rt;
    logic              load_use;

    logic              pc_write;
    pc_sel_t           pc_sel;
    logic              ifid_write;
    logic              ifid_flush;
    logic              idex_flush;
    logic              stall_inc;
    logic              flush_inc;

    assign ex_rt    = bus.ex_rt;
    // $zero is never a real dependency, so a load targeting it never stalls.
    assign load_use = bus.ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == bus.id_rs) || (ex_rt == bus.id_rt));

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        pc_write   = 1'b0;
        pc_sel     = PC_SEL_PC4;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;

        unique case (state_q)
            ST_HOLD: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            ST_RUN: begin
                if (bus.ex_branch_taken) begin
                    pc_sel     = PC_SEL_BRANCH;
                    pc_write   = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_inc  = 1'b1;
                end else if (bus.id_jump) begin
                    pc_sel     = PC_SEL_JUMP;
                    pc_write   = 1'b1;
                    ifid_flush = 1'b1;
                    flush_inc  = 1'b1;
                end else if (load_use) begin
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                end else if (!bus.imem_ready) begin
                    ifid_flush = 1'b1;
                    stall_inc  = 1'b1;
                    state_d    = ST_IMEM_WAIT;
                end else begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                end
            end

            ST_IMEM_WAIT: begin
                // A taken branch abandons the outstanding fetch entirely.
                if (bus.ex_branch_taken) begin
                    pc_sel     = PC_SEL_BRANCH;
                    pc_write   = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_inc  = 1'b1;
                    state_d    = ST_RUN;
                end else if (!bus.imem_ready) begin
                    ifid_flush = 1'b1;
                    stall_inc  = 1'b1;
                end else begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    state_d    = ST_RUN;
                end
            end

            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (stall_inc),
        .count_o (bus.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (flush_inc),
        .count_o (bus.flush_cnt)
    );

    // A flushed IF/ID must still be written or the NOP never lands.
    assign bus.pc_write   = pc_write;
    assign bus.pc_sel     = pc_sel;
    assign bus.ifid_write = ifid_write | ifid_flush;
    assign bus.ifid_flush = ifid_flush;
    assign bus.idex_flush = idex_flush;

endmodule : fetch_sequencer
